// File: rtl/jolt160_mem_ctrl.sv
// rtl/jolt160_mem_ctrl.sv - byte/halfword CPU-to-16-bit-RAM access controller
// Optional feature macro: JOLT160_MEM_CTRL_MISALIGN_SPLIT_EN (split misaligned 16-bit accesses)
module jolt160_mem_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  data_acc_sz,
  input  logic                  data_inout_we,
  input  logic [15:0]           temp_data_out,
  output logic [15:0]           temp_data_in,
  output logic                  data_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-2:0] ram_addr,
  output logic [15:0]           ram_wdata,
  output logic [1:0]            ram_be,
  output logic                  ram_we,
  input  logic [15:0]           ram_rdata
);

  typedef enum logic [2:0] {IDLE, WAIT, ACC1, LAT1, ACC2, LAT2, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef JOLT160_MEM_CTRL_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sz_q, sz_d;
  logic                  we_q, we_d;
  logic [15:0]           wdat_q, wdat_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [7:0]            lo_q, lo_d;
  logic [15:0]           temp_data_in_q, temp_data_in_d;
  logic                  data_ready_q, data_ready_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-2:0] ram_addr_q, ram_addr_d;
  logic [15:0]           ram_wdata_q, ram_wdata_d;
  logic [1:0]            ram_be_q, ram_be_d;
  logic                  ram_we_q, ram_we_d;

  // In IDLE the request fields come straight from the CPU, afterwards from the latches
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_sz, cur_we, misalign, go_acc1;
  logic [15:0]           cur_wdat;
  logic [ADDR_WIDTH-2:0] cur_word;

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    cur_addr = (state_q == IDLE) ? addr_in       : addr_q;
    cur_sz   = (state_q == IDLE) ? data_acc_sz   : sz_q;
    cur_we   = (state_q == IDLE) ? data_inout_we : we_q;
    cur_wdat = (state_q == IDLE) ? temp_data_out : wdat_q;
    cur_word = cur_addr[ADDR_WIDTH-1:1];
    misalign = cur_sz & cur_addr[0];

    state_d        = state_q;
    addr_d         = addr_q;
    sz_d           = sz_q;
    we_d           = we_q;
    wdat_d         = wdat_q;
    wait_cnt_d     = wait_cnt_q;
    lo_d           = lo_q;
    temp_data_in_d = temp_data_in_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_be_d       = 2'b00;
    ram_we_d       = 1'b0;
    data_ready_d   = 1'b0;
    go_acc1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_rdwr) begin
          addr_d     = addr_in;
          sz_d       = data_acc_sz;
          we_d       = data_inout_we;
          wdat_d     = temp_data_out;
          wait_cnt_d = 4'd0;
          if (misalign && !SPLIT_EN) begin
            // Unsupported misaligned halfword: complete at once, no RAM cycle
            state_d      = DONE;
            data_ready_d = 1'b1;
            if (!data_inout_we) temp_data_in_d = 16'h0000;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = ACC1;
            go_acc1 = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ACC1;
          go_acc1 = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ACC1: state_d = LAT1;
      LAT1: begin
        if (misalign && SPLIT_EN) begin
          // Low byte came from lane 1; high byte lives in lane 0 of the next word
          lo_d        = ram_rdata[15:8];
          state_d     = ACC2;
          ram_addr_d  = cur_word + 1'b1;
          ram_be_d    = 2'b01;
          ram_we_d    = cur_we;
          ram_wdata_d = {cur_wdat[15:8], cur_wdat[15:8]};
        end else begin
          state_d      = DONE;
          data_ready_d = 1'b1;
          if (!we_q) begin
            if (sz_q) temp_data_in_d = ram_rdata;
            else      temp_data_in_d = {8'h00, addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0]};
          end
        end
      end
      ACC2: state_d = LAT2;
      LAT2: begin
        state_d      = DONE;
        data_ready_d = 1'b1;
        if (!we_q) temp_data_in_d = {ram_rdata[7:0], lo_q};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // First RAM cycle: word, lane enables and lane-replicated byte data
    if (go_acc1) begin
      ram_addr_d = cur_word;
      ram_we_d   = cur_we;
      if (cur_sz && !cur_addr[0]) begin
        ram_be_d    = 2'b11;
        ram_wdata_d = cur_wdat;
      end else begin
        ram_be_d    = cur_addr[0] ? 2'b10 : 2'b01;
        ram_wdata_d = {cur_wdat[7:0], cur_wdat[7:0]};
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      sz_q           <= 1'b0;
      we_q           <= 1'b0;
      wdat_q         <= 16'h0000;
      wait_cnt_q     <= 4'd0;
      lo_q           <= 8'h00;
      temp_data_in_q <= 16'h0000;
      data_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= 16'h0000;
      ram_be_q       <= 2'b00;
      ram_we_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      sz_q           <= sz_d;
      we_q           <= we_d;
      wdat_q         <= wdat_d;
      wait_cnt_q     <= wait_cnt_d;
      lo_q           <= lo_d;
      temp_data_in_q <= temp_data_in_d;
      data_ready_q   <= data_ready_d;
      busy_q         <= busy_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_be_q       <= ram_be_d;
      ram_we_q       <= ram_we_d;
    end
  end

  assign temp_data_in = temp_data_in_q;
  assign data_ready   = data_ready_q;
  assign busy         = busy_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_be       = ram_be_q;
  assign ram_we       = ram_we_q;

endmodule

// File: tb/tb_jolt160_mem_ctrl.sv
// tb/tb_jolt160_mem_ctrl.sv - randomized self-checking bench for jolt160_mem_ctrl
module tb_jolt160_mem_ctrl;

  localparam int AW = 8;
  localparam int WS = 3;
`ifdef JOLT160_MEM_CTRL_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_rdwr = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          data_acc_sz = 1'b0;
  logic          data_inout_we = 1'b0;
  logic [15:0]   temp_data_out = 16'h0000;
  logic [15:0]   temp_data_in;
  logic          data_ready, busy;
  logic [AW-2:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [1:0]    ram_be;
  logic          ram_we;
  logic [15:0]   ram_rdata = 16'h0000;

  jolt160_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req_rdwr(req_rdwr), .addr_in(addr_in),
    .data_acc_sz(data_acc_sz), .data_inout_we(data_inout_we),
    .temp_data_out(temp_data_out), .temp_data_in(temp_data_in),
    .data_ready(data_ready), .busy(busy), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the controller, with a bench preload port
  logic [15:0]   mem [128];
  logic          pl_we = 1'b0;
  logic [6:0]    pl_addr = '0;
  logic [15:0]   pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference: byte-addressed memory and the value the CPU should currently see
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_tdi = 16'h0000;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [6:0] w, input logic [15:0] v);
    pl_addr = w; pl_data = v; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
    ref_mem[{w, 1'b0}] = v[7:0];
    ref_mem[{w, 1'b1}] = v[15:8];
  endtask

  // One CPU access from request to completion; entered and left on a falling edge
  task automatic run_access(input logic [7:0] a, input logic sz, input logic we, input logic [15:0] d);
    logic [7:0] a1;
    logic [6:0] w0;
    logic [1:0] exp_be;
    bit mis, done;
    int lat, ram_cyc, n, we_cnt, be_cnt;
    a1 = a + 8'd1;
    w0 = a[7:1];
    mis = sz & a[0];
    if (mis && !SPLIT) begin lat = 1; ram_cyc = 0; end
    else if (mis)      begin lat = 5 + WS; ram_cyc = 2; end
    else               begin lat = 3 + WS; ram_cyc = 1; end
    exp_be = (sz && !a[0]) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    if (!we) begin
      if (ram_cyc == 0) exp_tdi = 16'h0000;
      else if (sz)      exp_tdi = {ref_mem[a1], ref_mem[a]};
      else              exp_tdi = {8'h00, ref_mem[a]};
    end else if (ram_cyc != 0) begin
      ref_mem[a] = d[7:0];
      if (sz) ref_mem[a1] = d[15:8];
    end

    addr_in = a; data_acc_sz = sz; data_inout_we = we; temp_data_out = d; req_rdwr = 1'b1;
    n = 0; done = 0; we_cnt = 0; be_cnt = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_rdwr = 1'b0;
        check("busy_in_access", busy, 1);
      end
      if (ram_we) we_cnt++;
      if (ram_be != 2'b00) be_cnt++;
      if (ram_cyc > 0 && n == WS + 1) begin
        check("acc1_be", ram_be, exp_be);
        check("acc1_addr", ram_addr, w0);
        check("acc1_we", ram_we, we);
        if (we) begin
          if (exp_be == 2'b11)      check("acc1_wdata", ram_wdata, d);
          else if (exp_be == 2'b10) check("acc1_lane1", ram_wdata[15:8], d[7:0]);
          else                      check("acc1_lane0", ram_wdata[7:0], d[7:0]);
        end
      end
      if (ram_cyc == 2 && n == WS + 3) begin
        check("acc2_be", ram_be, 2'b01);
        check("acc2_addr", ram_addr, a1[7:1]);
        if (we) check("acc2_lane0", ram_wdata[7:0], d[15:8]);
      end
      if (data_ready) done = 1;
    end
    check("latency", n, lat);
    check("temp_data_in", temp_data_in, exp_tdi);
    check("we_cycles", we_cnt, we ? ram_cyc : 0);
    check("be_cycles", be_cnt, ram_cyc);
    @(negedge clk);
    check("ready_pulse", data_ready, 0);
    check("idle_after", busy, 0);
  endtask

  int mism, pulses, p1, p2, cnt;

  initial begin
    // Preload RAM while the controller is held in reset
    for (int w = 0; w < 128; w++) begin
      @(negedge clk);
      poke(7'(w), 16'($urandom));
    end
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 0);
    check("rst_tdi", temp_data_in, 0);
    check("rst_we", ram_we, 0);
    check("rst_be", ram_be, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Aligned halfword read
    poke(7'h08, 16'hBEEF);
    run_access(8'h10, 1'b1, 1'b0, 16'h0000);
    check("beef", temp_data_in, 16'hBEEF);
    // Byte write to the odd lane; upper data bits must be ignored
    run_access(8'h21, 1'b0, 1'b1, 16'hAB12);
    run_access(8'h20, 1'b1, 1'b0, 16'h0000);
    // Misaligned halfword read spanning words 1 and 2
    poke(7'h01, 16'hAA00);
    poke(7'h02, 16'h00BB);
    run_access(8'h03, 1'b1, 1'b0, 16'h0000);
    check("misalign_rd", temp_data_in, SPLIT ? 16'hBBAA : 16'h0000);
    // Top-of-memory wrap
    run_access(8'hFF, 1'b1, 1'b1, 16'h5A3C);
    run_access(8'hFF, 1'b1, 1'b0, 16'h0000);
    run_access(8'h00, 1'b0, 1'b0, 16'h0000);

    // Reset during the wait phase abandons the write
    addr_in = 8'h40; data_acc_sz = 1'b0; data_inout_we = 1'b1; temp_data_out = 16'h0077;
    req_rdwr = 1'b1;
    @(negedge clk);
    req_rdwr = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_tdi = 16'h0000;
    check("abort_busy", busy, 0);
    check("abort_ready", data_ready, 0);
    check("abort_we", ram_we, 0);
    check("abort_tdi", temp_data_in, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_ready || ram_we) cnt++;
    end
    check("abort_quiet", cnt, 0);
    run_access(8'h40, 1'b0, 1'b0, 16'h0000);

    // Request held high: exactly one completion per accepted request
    addr_in = 8'h10; data_acc_sz = 1'b1; data_inout_we = 1'b0; req_rdwr = 1'b1;
    pulses = 0; p1 = 0; p2 = 0;
    for (int n = 1; n <= 2 * (3 + WS) + 6; n++) begin
      @(negedge clk);
      if (data_ready) begin
        pulses++;
        if (pulses == 1) p1 = n;
        if (pulses == 2) p2 = n;
      end
      if (n == 2 * (3 + WS) + 1) req_rdwr = 1'b0;
    end
    exp_tdi = {ref_mem[8'h11], ref_mem[8'h10]};
    check("held_pulses", pulses, 2);
    check("held_first", p1, 3 + WS);
    check("held_second", p2, 2 * (3 + WS) + 1);
    check("held_tdi", temp_data_in, exp_tdi);

    // Random traffic against the reference
    for (int i = 0; i < 200; i++) begin
      run_access(8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    mism = 0;
    for (int w = 0; w < 128; w++) begin
      if (mem[w] !== {ref_mem[2 * w + 1], ref_mem[2 * w]}) mism++;
    end
    check("ram_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
